packet_source: RTL and testbench
================================

// Module: packet_source
// PURPOSE
//  Per-port traffic generator; the transmit end of the packet_t link that packet_sink terminates.
//  Bernoulli-injects packets: LFSR-random destination, current timestamp stamped in data[15:0].
//  Buffers packets in a local FIFO and hands them to the network with a valid/ready handshake.
//  One instance per network input port.
// PARAMETERS
//  port_no     0        this source's port index; never used as a destination
//  PORTS       8        number of network ports; legal destinations are 0..PORTS-1
//  FIFO_DEPTH  8        injection FIFO entries, power of 2, >=2
//  RATE        8'd64    injection threshold; inject when lfsr[7:0] < RATE (64/256 = 25%)
//  SEED        16'hACE1 LFSR reset value, nonzero
// PORTS
//  clk          in   1       clock
//  rst          in   1       asynchronous reset, active-high
//  enable       in   1       generation enable; draining continues when low
//  timestamp    in   16      free-running cycle count shared with the sinks
//  tx_ready     in   1       network accepts pkt_tx this cycle
//  pkt_tx       out  packet_t  outgoing packet (valid, dest, data)
//  pkt_count    out  16      packets accepted by the network (valid & tx_ready)
//  drop_count   out  16      generated packets lost to a full FIFO, saturates at 16'hFFFF
//  fifo_level   out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset (async assert, sync release): lfsr=SEED; FIFO empty; pkt_tx all-zero (valid=0).
//    pkt_count=0, drop_count=0, fifo_level=0.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11. Steps every cycle enable=1, holds otherwise.
//  Generate: in a cycle with enable=1 and lfsr[7:0] < RATE, form one packet from the pre-step lfsr.
//    dest = lfsr[15:8] mod PORTS; if dest==port_no then dest=(dest+1) mod PORTS.
//    data[15:0]=timestamp (value in the generate cycle); remaining data bits=0; valid=1.
//  FIFO push: the generated packet is pushed the same cycle.
//    If FIFO full and no pop this cycle: packet dropped, drop_count+1 (saturating).
//    Full with a simultaneous pop: push accepted, no drop.
//  Output stage: pkt_tx is a register loaded from the FIFO head.
//    pkt_tx.valid=1 whenever a packet is held. Latency is 2 cycles:
//    generate in cycle N -> pkt_tx.valid in cycle N+2, provided the FIFO and output stage were empty.
//  Handshake: transfer when pkt_tx.valid & tx_ready.
//    While valid & !tx_ready, pkt_tx is held bit-stable.
//    On transfer the register reloads from the FIFO head the same edge (back-to-back, 1 pkt/cycle).
//    If the FIFO is empty, valid drops to 0. tx_ready while valid=0 has no effect.
//  pkt_count +1 per transfer, wraps at 2^16. fifo_level excludes the output register.
//  enable low: no generation and the LFSR freezes; queued packets still drain.
//  Reset mid-operation: all queued and held packets discarded; counters cleared.
//  No combinational path from tx_ready to pkt_tx.
// STRUCTURE
//  Shared package (config.sv): packet_t, PORT_BITS, TS_BITS=16, LFSR taps constant.
//  Sub-module pkt_fifo: synchronous FIFO of packet_t with push, pop, full, empty, level.
//    Same-cycle push+pop is allowed when full.
//  packet_source top holds the LFSR, destination mapping, output register and counters.
// TESTING
//  1. RATE=0, enable=1 for 1000 cycles -> pkt_tx.valid never 1; pkt_count=0; drop_count=0.
//  2. RATE=8'hFF, tx_ready=1, port_no=3, PORTS=8 -> dest never 3 and always <8.
//     Each data[15:0] equals transfer-cycle timestamp minus 2.
//  3. RATE=8'hFF, tx_ready=0, FIFO_DEPTH=8 -> fifo_level reaches 8; pkt_tx stays stable.
//     drop_count increments every later generate cycle.
//  4. Backpressure toggle: tx_ready=1010... with full FIFO -> each packet transferred exactly once, in order.
//     pkt_count equals the sink-side count; no drops while pop and push coincide.
//  5. Assert rst mid-burst (async, between edges) -> pkt_tx.valid=0 immediately; counters 0.
//     After release, first generated packet reproduces the post-reset sequence from SEED.
//  6. End-to-end with packet_sink port_no=dest loopback -> sink pkt_error=0.
//     Sink latency sum = 2 x packets at zero backpressure.

Source files
------------

// File: rtl/packet_source_pkg.sv
// Shared types and helpers for the packet_t link: packet layout, LFSR step and destination mapping.
package packet_source_pkg;

    localparam int PORT_BITS = 8;
    localparam int TS_BITS   = 16;
    localparam int DATA_BITS = 32;

    // Fibonacci taps 16,14,13,11 expressed as state bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic                 valid;
        logic [PORT_BITS-1:0] dest;
        logic [DATA_BITS-1:0] data;
    } packet_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    // A source never targets itself: its own index is bumped to the next port.
    function automatic logic [PORT_BITS-1:0] map_dest(input logic [7:0] r, input int ports,
                                                      input int self_port);
        int d;
        d = int'(r) % ports;
        if (d == self_port) d = (d + 1) % ports;
        return d[PORT_BITS-1:0];
    endfunction

endpackage

// File: rtl/packet_source_fifo.sv
// Synchronous packet_t FIFO; a push is legal while full when a pop happens the same cycle.
module pkt_fifo
    import packet_source_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  packet_t                  push_pkt,
    input  logic                     pop,
    output packet_t                  head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]            wr_q, wr_d, rd_q, rd_d;
    packet_t [DEPTH-1:0]    mem_q, mem_d;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_q[AW-1:0]] = push_pkt;
            wr_d                = wr_q + 1'b1;
        end
        if (pop) rd_d = rd_q + 1'b1;
    end

    assign level = wr_q - rd_q;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);
    assign head  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/packet_source.sv
// Per-port Bernoulli traffic generator: LFSR-driven injection into a FIFO, drained through a
// registered valid/ready output stage.
module packet_source
    import packet_source_pkg::*;
#(
    parameter int          port_no    = 0,
    parameter int          PORTS      = 8,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [7:0]  RATE       = 8'd64,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [TS_BITS-1:0]            timestamp,
    input  logic                          tx_ready,
    output packet_t                       pkt_tx,
    output logic [15:0]                   pkt_count,
    output logic [15:0]                   drop_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    logic [15:0] lfsr_q, lfsr_d;
    packet_t     out_q, out_d;
    logic [15:0] pkt_count_q, pkt_count_d;
    logic [15:0] drop_count_q, drop_count_d;

    packet_t gen_pkt, head;
    logic    gen, load, pop, push, full, empty;

    always_comb begin
        gen    = enable && (lfsr_q[7:0] < RATE);
        lfsr_d = enable ? lfsr_next(lfsr_q) : lfsr_q;

        gen_pkt                   = '0;
        gen_pkt.valid             = 1'b1;
        gen_pkt.dest              = map_dest(lfsr_q[15:8], PORTS, port_no);
        gen_pkt.data[TS_BITS-1:0] = timestamp;

        // The output register refills whenever it is empty or being handed off this cycle.
        load = !out_q.valid || tx_ready;
        pop  = load && !empty;
        push = gen && (!full || pop);

        out_d = out_q;
        if (load) out_d = empty ? '0 : head;

        pkt_count_d  = pkt_count_q + {15'd0, out_q.valid & tx_ready};
        drop_count_d = drop_count_q;
        if (gen && full && !pop && drop_count_q != 16'hFFFF)
            drop_count_d = drop_count_q + 16'd1;
    end

    pkt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_pkt (gen_pkt),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .level    (fifo_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q       <= SEED;
            out_q        <= '0;
            pkt_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            lfsr_q       <= lfsr_d;
            out_q        <= out_d;
            pkt_count_q  <= pkt_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign pkt_tx     = out_q;
    assign pkt_count  = pkt_count_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_packet_source.sv
// Directed bench for packet_source: a rate-0 instance plus a full-rate port-3 instance
// checked against a small injection/occupancy scoreboard.
module tb_packet_source;
    import packet_source_pkg::*;

    localparam int          DEPTH = 8;
    localparam logic [7:0]  RATE1 = 8'hFF;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, tx_ready = 1'b0;
    logic [15:0] timestamp = 16'd0;
    packet_t     pkt0, pkt1;
    logic [15:0] pc0, dc0, pc1, dc1;
    logic [3:0]  lvl0, lvl1;

    int checks = 0;
    int errors = 0;

    logic [15:0] lfsr_m;
    packet_t     exp_q[$];
    int          pkt_m, drop_m;

    packet_source #(.port_no(0), .PORTS(8), .FIFO_DEPTH(DEPTH), .RATE(8'd0), .SEED(SEED)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .timestamp(timestamp), .tx_ready(tx_ready),
        .pkt_tx(pkt0), .pkt_count(pc0), .drop_count(dc0), .fifo_level(lvl0));

    packet_source #(.port_no(3), .PORTS(8), .FIFO_DEPTH(DEPTH), .RATE(RATE1), .SEED(SEED)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .timestamp(timestamp), .tx_ready(tx_ready),
        .pkt_tx(pkt1), .pkt_count(pc1), .drop_count(dc1), .fifo_level(lvl1));

    always #5 clk = ~clk;
    always @(posedge clk) timestamp <= timestamp + 16'd1;

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [7:0] ref_dest(input logic [7:0] r);
        logic [7:0] d;
        d = r % 8;
        if (d == 8'd3) d = 8'd4;
        return d;
    endfunction

    task automatic model_clear();
        lfsr_m = SEED;
        exp_q.delete();
        pkt_m  = 0;
        drop_m = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; tx_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    // Drives one cycle's inputs and predicts what dut1 does at the coming edge.
    task automatic cycle(input logic en, input logic rdy, output logic xfer, output packet_t got,
                         output packet_t exp, output logic eok);
        packet_t p;
        @(negedge clk);
        enable = en; tx_ready = rdy;
        xfer = pkt1.valid && rdy;
        got  = pkt1;
        exp  = '0;
        eok  = 1'b0;
        if (xfer) begin
            pkt_m++;
            if (exp_q.size() > 0) begin exp = exp_q.pop_front(); eok = 1'b1; end
        end
        if (en) begin
            if (lfsr_m[7:0] < RATE1) begin
                p = '0; p.valid = 1'b1; p.dest = ref_dest(lfsr_m[15:8]); p.data[15:0] = timestamp;
                if (exp_q.size() < DEPTH + 1) exp_q.push_back(p);
                else if (drop_m < 65535) drop_m++;
            end
            lfsr_m = ref_step(lfsr_m);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        enable = 1'b0; tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (pkt1 !== '0) begin errors++; $display("FAIL reset_pkt_tx: got %h want 0", pkt1); end
        checks++; if (pc1 !== 16'd0) begin errors++; $display("FAIL reset_pkt_count: got %0d want 0", pc1); end
        checks++; if (dc1 !== 16'd0) begin errors++; $display("FAIL reset_drop_count: got %0d want 0", dc1); end
        checks++; if (lvl1 !== 4'd0) begin errors++; $display("FAIL reset_fifo_level: got %0d want 0", lvl1); end
        checks++; if (pkt0.valid !== 1'b0) begin errors++; $display("FAIL reset_valid0: got %b want 0", pkt0.valid); end
    endtask

    task automatic test_rate_zero();
        logic xfer, eok, seen;
        packet_t got, exp;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b1, 1'b1, xfer, got, exp, eok);
            if (pkt0.valid) seen = 1'b1;
        end
        idle();
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rate0_valid: got %b want 0", seen); end
        checks++; if (pc0 !== 16'd0) begin errors++; $display("FAIL rate0_pkt_count: got %0d want 0", pc0); end
        checks++; if (dc0 !== 16'd0) begin errors++; $display("FAIL rate0_drop_count: got %0d want 0", dc0); end
        checks++; if (lvl0 !== 4'd0) begin errors++; $display("FAIL rate0_level: got %0d want 0", lvl0); end
    endtask

    task automatic test_dest_latency();
        logic xfer, eok;
        packet_t got, exp;
        logic [7:0] hand [4];
        int n, lat_sum;
        hand[0] = 8'd4; hand[1] = 8'd1; hand[2] = 8'd4; hand[3] = 8'd7;
        n = 0; lat_sum = 0;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1, 1'b1, xfer, got, exp, eok);
            if (xfer) begin
                checks++;
                if (!eok || got !== exp) begin errors++; $display("FAIL dest_order: got %h want %h", got, exp); end
                checks++;
                if (got.dest == 8'd3 || got.dest >= 8'd8) begin
                    errors++; $display("FAIL dest_range: got %0d want <8 and !=3", got.dest);
                end
                checks++;
                if (got.data !== {16'd0, timestamp - 16'd2}) begin
                    errors++; $display("FAIL data_timestamp: got %h want %h", got.data, {16'd0, timestamp - 16'd2});
                end
                if (n < 4) begin
                    checks++;
                    if (got.dest !== hand[n]) begin
                        errors++; $display("FAIL first_dest%0d: got %0d want %0d", n, got.dest, hand[n]);
                    end
                end
                lat_sum += int'(16'(timestamp - got.data[15:0]));
                n++;
            end
        end
        idle();
        checks++; if (lat_sum != 2 * n) begin errors++; $display("FAIL latency_sum: got %0d want %0d", lat_sum, 2 * n); end
        checks++; if (pc1 !== 16'(n)) begin errors++; $display("FAIL dl_pkt_count: got %0d want %0d", pc1, n); end
        checks++; if (dc1 !== 16'd0) begin errors++; $display("FAIL dl_drop_count: got %0d want 0", dc1); end
    endtask

    task automatic test_fill_drop();
        logic xfer, eok, have, moved;
        packet_t got, exp, held;
        logic [3:0] maxlvl;
        have = 1'b0; moved = 1'b0; maxlvl = 4'd0; held = '0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b0, xfer, got, exp, eok);
            if (lvl1 > maxlvl) maxlvl = lvl1;
            if (pkt1.valid) begin
                if (!have) begin held = pkt1; have = 1'b1; end
                else if (pkt1 !== held) moved = 1'b1;
            end
        end
        idle();
        checks++; if (maxlvl !== 4'd8) begin errors++; $display("FAIL fill_max_level: got %0d want 8", maxlvl); end
        checks++; if (lvl1 !== 4'd8) begin errors++; $display("FAIL fill_level: got %0d want 8", lvl1); end
        checks++; if (moved !== 1'b0) begin errors++; $display("FAIL fill_stable: got %b want 0", moved); end
        checks++; if (pkt1 !== exp_q[0]) begin errors++; $display("FAIL fill_head: got %h want %h", pkt1, exp_q[0]); end
        checks++; if (dc1 !== 16'(drop_m)) begin errors++; $display("FAIL fill_drops: got %0d want %0d", dc1, drop_m); end
        checks++; if (pc1 !== 16'd0) begin errors++; $display("FAIL fill_pkt_count: got %0d want 0", pc1); end
    endtask

    task automatic test_backpressure_toggle();
        logic xfer, eok;
        packet_t got, exp;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'((i % 2) == 0), xfer, got, exp, eok);
            if (xfer) begin
                checks++;
                if (!eok || got !== exp) begin errors++; $display("FAIL toggle_order: got %h want %h", got, exp); end
            end
        end
        idle();
        checks++; if (pc1 !== 16'(pkt_m)) begin errors++; $display("FAIL toggle_pkt_count: got %0d want %0d", pc1, pkt_m); end
        checks++; if (dc1 !== 16'(drop_m)) begin errors++; $display("FAIL toggle_drops: got %0d want %0d", dc1, drop_m); end
        checks++;
        if (int'(lvl1) + int'(pkt1.valid) != exp_q.size()) begin
            errors++; $display("FAIL toggle_occupancy: got %0d want %0d", int'(lvl1) + int'(pkt1.valid), exp_q.size());
        end
    endtask

    task automatic test_enable_drain();
        logic xfer, eok;
        packet_t got, exp;
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, 1'b1, xfer, got, exp, eok);
            if (xfer) begin
                checks++;
                if (!eok || got !== exp) begin errors++; $display("FAIL drain_order: got %h want %h", got, exp); end
            end
        end
        idle();
        checks++; if (lvl1 !== 4'd0) begin errors++; $display("FAIL drain_level: got %0d want 0", lvl1); end
        checks++; if (pkt1.valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", pkt1.valid); end
        checks++; if (pc1 !== 16'(pkt_m)) begin errors++; $display("FAIL drain_pkt_count: got %0d want %0d", pc1, pkt_m); end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, xfer, got, exp, eok);
            if (xfer) begin
                checks++;
                if (!eok || got !== exp) begin errors++; $display("FAIL resume_order: got %h want %h", got, exp); end
            end
        end
        idle();
        checks++; if (pc1 !== 16'(pkt_m)) begin errors++; $display("FAIL resume_pkt_count: got %0d want %0d", pc1, pkt_m); end
    endtask

    task automatic test_async_reset();
        logic xfer, eok, first;
        packet_t got, exp;
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, xfer, got, exp, eok);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (pkt1.valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", pkt1.valid); end
        checks++; if (pc1 !== 16'd0) begin errors++; $display("FAIL arst_pkt_count: got %0d want 0", pc1); end
        checks++; if (dc1 !== 16'd0) begin errors++; $display("FAIL arst_drop_count: got %0d want 0", dc1); end
        checks++; if (lvl1 !== 4'd0) begin errors++; $display("FAIL arst_level: got %0d want 0", lvl1); end
        @(negedge clk);
        enable = 1'b0; tx_ready = 1'b0; rst = 1'b0;
        model_clear();
        first = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b1, xfer, got, exp, eok);
            if (xfer) begin
                checks++;
                if (!eok || got !== exp) begin errors++; $display("FAIL arst_seq: got %h want %h", got, exp); end
                if (first) begin
                    checks++;
                    if (got.dest !== 8'd4) begin errors++; $display("FAIL arst_first_dest: got %0d want 4", got.dest); end
                    first = 1'b0;
                end
            end
        end
        idle();
        checks++; if (pc1 !== 16'(pkt_m)) begin errors++; $display("FAIL arst_pkt_count_after: got %0d want %0d", pc1, pkt_m); end
    endtask

    initial begin
        model_clear();
        do_reset();
        test_reset();
        test_rate_zero();
        do_reset();
        test_dest_latency();
        do_reset();
        test_fill_drop();
        test_backpressure_toggle();
        test_enable_drain();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
